// File: rtl/gpr_sb_regfile.sv
// General-purpose register file with N combinational read ports, one writeback
// port, optional writeback-to-read forwarding and a per-register pending-write scoreboard.
module gpr_sb_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 2,
  parameter int PEND_WIDTH = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RPORTS-1:0]            rd_en,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RPORTS-1:0]            rd_busy,
  input  logic                             iss_valid,
  input  logic [ADDR_WIDTH-1:0]            iss_rd,
  output logic                             iss_ready,
  input  logic                             wb_valid,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0]            wb_data,
  input  logic                             flush,
  output logic                             wb_err
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  logic [DATA_WIDTH-1:0] regs    [NREG];
  logic [PEND_WIDTH-1:0] cnt     [NREG];
  logic [PEND_WIDTH-1:0] cnt_nxt [NREG];
  logic                  err_q;

  logic wb_act;
  logic wb_dec;
  logic iss_act;
  logic iss_full;
  logic wb_hit_iss;
  logic iss_inc;

  // Writes and issues to x0 are swallowed here, so cnt[0] and regs[0] never move.
  assign wb_act     = wb_valid && (wb_addr != '0);
  assign wb_dec     = wb_act && (cnt[wb_addr] != '0);
  assign iss_act    = iss_valid && (iss_rd != '0) && !flush;
  assign iss_full   = (cnt[iss_rd] == PEND_MAX);
  assign wb_hit_iss = wb_dec && (wb_addr == iss_rd);

  // Handshake: an allocation transfers on a posedge where iss_valid && iss_ready.
  // iss_ready is combinational and drops only when the target counter is saturated
  // and no same-cycle decrementing writeback frees a slot; a refused issue has no effect.
  assign iss_ready = rst || !(iss_act && iss_full && !wb_hit_iss);
  assign iss_inc   = iss_act && iss_ready;

  assign wb_err = err_q;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [PEND_WIDTH-1:0] c;
    logic                  live;
    logic                  byp;

    assign a    = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign c    = cnt[a];
    assign live = rd_en[p] && !rst && (a != '0);
    assign byp  = (BYPASS != 0) && wb_valid && (wb_addr == a);

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = !live ? '0 : (byp ? wb_data : regs[a]);
    // A forwarded writeback retires one outstanding write, so one pending is not busy.
    assign rd_busy[p] = live && (byp ? (c > PEND_WIDTH'(1)) : (c != '0));
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (flush) begin
        cnt_nxt[r] = '0;
      end else begin
        if (iss_inc && (iss_rd == ADDR_WIDTH'(r)) && !(wb_dec && (wb_addr == ADDR_WIDTH'(r))))
          cnt_nxt[r] = cnt[r] + PEND_WIDTH'(1);
        else if (wb_dec && (wb_addr == ADDR_WIDTH'(r)) && !(iss_inc && (iss_rd == ADDR_WIDTH'(r))))
          cnt_nxt[r] = cnt[r] - PEND_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      if (wb_act) begin
        regs[wb_addr] <= wb_data;
        // Error check uses the pre-flush count, so a flush does not mask it.
        if (cnt[wb_addr] == '0)
          err_q <= 1'b1;
      end
    end
  end

endmodule
